// File: rtl/wb_master_port.sv
// wb_master_port: single-outstanding classic Wishbone initiator.
// A client request (valid/ready) becomes one Wishbone cycle. The cycle ends on
// err_i, ack_i or rty_i (in that priority). A retried cycle is reissued after a
// one-cycle gap, up to MAX_RETRY extra attempts. The result comes back on a
// valid/ready response channel with a 2-bit status code.
// Optional feature: define WB_MASTER_TIMEOUT_EN to abort a cycle that has had
// no termination for TIMEOUT_CYCLES cycles (status 11).
module wb_master_port #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_bus,
    input  logic                    rst_bus,
    // client request channel
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_adr,
    input  logic [DATA_WIDTH-1:0]   req_dat,
    input  logic [DATA_WIDTH/8-1:0] req_sel,
    // client response channel
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_dat,
    output logic [1:0]              resp_code,
    // Wishbone initiator side
    output logic                    cyc_o,
    output logic                    stb_o,
    output logic                    we_o,
    output logic [ADDR_WIDTH-1:0]   adr_o,
    output logic [DATA_WIDTH-1:0]   dat_o,
    output logic [DATA_WIDTH/8-1:0] sel_o,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    input  logic                    ack_i,
    input  logic                    err_i,
    input  logic                    rty_i
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] CODE_OK  = 2'b00;
    localparam logic [1:0] CODE_ERR = 2'b01;
    localparam logic [1:0] CODE_RTY = 2'b10;

    localparam logic [3:0] MAX_RETRY_C = 4'(MAX_RETRY);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUS     = 2'd1,
        ST_BACKOFF = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    state_t                  state_reg, state_next;
    logic [3:0]              retry_cnt_reg, retry_cnt_next;

    logic                    req_ready_reg, req_ready_next;
    logic                    resp_valid_reg, resp_valid_next;
    logic [DATA_WIDTH-1:0]   resp_dat_reg, resp_dat_next;
    logic [1:0]              resp_code_reg, resp_code_next;

    logic                    cyc_reg, stb_reg, cyc_next;
    logic                    we_reg, we_next;
    logic [ADDR_WIDTH-1:0]   adr_reg, adr_next;
    logic [DATA_WIDTH-1:0]   dat_reg, dat_next;
    logic [SEL_WIDTH-1:0]    sel_reg, sel_next;

    // read data returned on ack: slave data for reads, zero for writes
    logic [DATA_WIDTH-1:0]   ack_rdata;

    // wait-counter control from the FSM; only consumed when timeout is built
    logic                    wait_clr;
    logic                    wait_inc;
    logic                    timeout_hit;

    // Per byte lane: forward slave data on reads, force zero on writes.
    genvar gi;
    generate
        for (gi = 0; gi < SEL_WIDTH; gi = gi + 1) begin : g_lane
            assign ack_rdata[gi*8 +: 8] = we_reg ? 8'h00 : dat_i[gi*8 +: 8];
        end
    endgenerate

`ifdef WB_MASTER_TIMEOUT_EN
    localparam logic [1:0]  CODE_TMO     = 2'b11;
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wait_cnt_reg, wait_cnt_next;

    // The current BUS cycle is the last one allowed without termination.
    assign timeout_hit = (wait_cnt_reg == TIMEOUT_LAST);

    // Count unterminated BUS cycles; restart on every entry to BUS.
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (wait_clr) begin
            wait_cnt_next = 16'd0;
        end else if (wait_inc) begin
            wait_cnt_next = wait_cnt_reg + 16'd1;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk_bus or posedge rst_bus) begin
        if (rst_bus) begin
            wait_cnt_reg <= 16'd0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end
`else
    // Without the timeout the bus waits indefinitely for a termination.
    assign timeout_hit = 1'b0;

    logic unused_timeout;
    assign unused_timeout = wait_clr ^ wait_inc ^ (^TIMEOUT_CYCLES);
`endif

    // Next-state and registered-output logic of the transfer FSM.
    always_comb begin
        state_next      = state_reg;
        retry_cnt_next  = retry_cnt_reg;
        req_ready_next  = req_ready_reg;
        resp_valid_next = resp_valid_reg;
        resp_dat_next   = resp_dat_reg;
        resp_code_next  = resp_code_reg;
        cyc_next        = cyc_reg;
        we_next         = we_reg;
        adr_next        = adr_reg;
        dat_next        = dat_reg;
        sel_next        = sel_reg;
        wait_clr        = 1'b0;
        wait_inc        = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                // req_ready is 0 only on the first edge after reset release
                req_ready_next = 1'b1;
                if (req_valid && req_ready_reg) begin
                    we_next        = req_we;
                    adr_next       = req_adr;
                    dat_next       = req_dat;
                    sel_next       = req_sel;
                    retry_cnt_next = 4'd0;
                    cyc_next       = 1'b1;
                    req_ready_next = 1'b0;
                    wait_clr       = 1'b1;
                    state_next     = ST_BUS;
                end
            end

            ST_BUS: begin
                if (err_i) begin
                    cyc_next        = 1'b0;
                    resp_valid_next = 1'b1;
                    resp_dat_next   = '0;
                    resp_code_next  = CODE_ERR;
                    state_next      = ST_RESP;
                end else if (ack_i) begin
                    cyc_next        = 1'b0;
                    resp_valid_next = 1'b1;
                    resp_dat_next   = ack_rdata;
                    resp_code_next  = CODE_OK;
                    state_next      = ST_RESP;
                end else if (rty_i) begin
                    cyc_next = 1'b0;
                    if (retry_cnt_reg < MAX_RETRY_C) begin
                        retry_cnt_next = retry_cnt_reg + 4'd1;
                        state_next     = ST_BACKOFF;
                    end else begin
                        resp_valid_next = 1'b1;
                        resp_dat_next   = '0;
                        resp_code_next  = CODE_RTY;
                        state_next      = ST_RESP;
                    end
                end else if (timeout_hit) begin
`ifdef WB_MASTER_TIMEOUT_EN
                    cyc_next        = 1'b0;
                    resp_valid_next = 1'b1;
                    resp_dat_next   = '0;
                    resp_code_next  = CODE_TMO;
                    state_next      = ST_RESP;
`endif
                end else begin
                    wait_inc = 1'b1;
                end
            end

            ST_BACKOFF: begin
                // one idle bus cycle, then reissue the same latched request
                cyc_next   = 1'b1;
                wait_clr   = 1'b1;
                state_next = ST_BUS;
            end

            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_next = 1'b0;
                    resp_dat_next   = '0;
                    resp_code_next  = CODE_OK;
                    req_ready_next  = 1'b1;
                    state_next      = ST_IDLE;
                end
            end

            default: begin
                cyc_next        = 1'b0;
                resp_valid_next = 1'b0;
                req_ready_next  = 1'b0;
                state_next      = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any cycle and pending response.
    always_ff @(posedge clk_bus or posedge rst_bus) begin
        if (rst_bus) begin
            state_reg      <= ST_IDLE;
            retry_cnt_reg  <= 4'd0;
            req_ready_reg  <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_dat_reg   <= '0;
            resp_code_reg  <= 2'b00;
            cyc_reg        <= 1'b0;
            stb_reg        <= 1'b0;
            we_reg         <= 1'b0;
            adr_reg        <= '0;
            dat_reg        <= '0;
            sel_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            retry_cnt_reg  <= retry_cnt_next;
            req_ready_reg  <= req_ready_next;
            resp_valid_reg <= resp_valid_next;
            resp_dat_reg   <= resp_dat_next;
            resp_code_reg  <= resp_code_next;
            cyc_reg        <= cyc_next;
            stb_reg        <= cyc_next;
            we_reg         <= we_next;
            adr_reg        <= adr_next;
            dat_reg        <= dat_next;
            sel_reg        <= sel_next;
        end
    end

    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_dat   = resp_dat_reg;
    assign resp_code  = resp_code_reg;
    assign cyc_o      = cyc_reg;
    assign stb_o      = stb_reg;
    assign we_o       = we_reg;
    assign adr_o      = adr_reg;
    assign dat_o      = dat_reg;
    assign sel_o      = sel_reg;

endmodule

// File: tb/tb_wb_master_port.sv
// Testbench for wb_master_port: directed vector table, randomized transfers
// against a behavioural model, and reset-in-flight sequence.
// Define WB_MASTER_TIMEOUT_EN to also exercise the timeout abort.
module tb_wb_master_port;

    localparam int MAXR = 3;
    localparam int TMO  = 8;
    localparam int BUDGET = 300;

    localparam logic [2:0] T_RTY = 3'b001;
    localparam logic [2:0] T_ACK = 3'b010;
    localparam logic [2:0] T_ERR = 3'b100;

    logic        clk_bus = 1'b0;
    logic        rst_bus = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_adr = '0;
    logic [31:0] req_dat = '0;
    logic [3:0]  req_sel = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_dat;
    logic [1:0]  resp_code;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] adr_o, dat_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i = '0;
    logic        ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0;

    int total = 0;
    int bad   = 0;

    wb_master_port #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_RETRY(MAXR), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_bus(clk_bus), .rst_bus(rst_bus),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_dat(resp_dat), .resp_code(resp_code),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
        .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o),
        .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
    );

    always #5 clk_bus = ~clk_bus;

    // One transfer: request, slave script per attempt, response expectations.
    typedef struct packed {
        logic             we;
        logic [31:0]      adr;
        logic [31:0]      dat;
        logic [3:0]       sel;
        logic [31:0]      rdata;
        logic [5:0][15:0] waits;  // wait states before termination, per attempt
        logic [5:0][2:0]  term;   // {err, ack, rty} asserted at that cycle
        logic [7:0]       rr_delay;
        logic [1:0]       exp_code;
        logic [31:0]      exp_dat;
        logic [15:0]      exp_cyc;
        logic [3:0]       exp_att;
        logic [15:0]      exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, input logic [31:0] rdata, input int rr,
                                input logic [1:0] code, input logic [31:0] edat,
                                input int ecyc, input int eatt, input int elat);
        vec_t v;
        v = '0;
        v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.rdata = rdata;
        for (int k = 0; k < 6; k++) begin
            v.waits[k] = 16'd0;
            v.term[k]  = T_ACK;
        end
        v.rr_delay = 8'(rr);
        v.exp_code = code; v.exp_dat = edat;
        v.exp_cyc = 16'(ecyc); v.exp_att = 4'(eatt); v.exp_lat = 16'(elat);
        return v;
    endfunction

    // Behavioural outcome of a script: walk attempts in order.
    function automatic vec_t model(input vec_t vin);
        vec_t v;
        int cyc, att;
        v = vin;
        v.exp_code = 2'b10;
        v.exp_dat  = '0;
        cyc = 0;
        att = 0;
        for (int k = 0; k <= MAXR; k++) begin
            att = k + 1;
`ifdef WB_MASTER_TIMEOUT_EN
            if (int'(v.waits[k]) >= TMO) begin
                cyc += TMO;
                v.exp_code = 2'b11;
                break;
            end
`endif
            cyc += int'(v.waits[k]) + 1;
            if (v.term[k][2]) begin
                v.exp_code = 2'b01;
                break;
            end
            if (v.term[k][1]) begin
                v.exp_code = 2'b00;
                v.exp_dat  = v.we ? 32'h0 : v.rdata;
                break;
            end
        end
        v.exp_cyc = 16'(cyc);
        v.exp_att = 4'(att);
        v.exp_lat = 16'(cyc + att - 1);
        return v;
    endfunction

    // Run one transfer; called and returning just after a falling edge.
    task automatic run_txn(input vec_t v, input bit noisy, input string tag);
        int tick, acc_tick, cyc_cnt, att, c, lat, hold;
        bit prev_cyc, got, done, stable_ok, hold_ok, post_ok;
        logic [31:0] r_dat;
        logic [1:0]  r_code;
        tick = 0; acc_tick = -1; cyc_cnt = 0; att = 0; c = 0; lat = 0; hold = 0;
        prev_cyc = 0; got = 0; done = 0; stable_ok = 1; hold_ok = 1; post_ok = 0;
        r_dat = '0; r_code = '0;
        req_valid = 1'b1; req_we = v.we; req_adr = v.adr; req_dat = v.dat; req_sel = v.sel;
        resp_ready = 1'b0;
        {err_i, ack_i, rty_i} = 3'b000;
        while (!done && tick < BUDGET) begin
            if (acc_tick < 0 && req_valid && req_ready) acc_tick = tick + 1;
            if (cyc_o) begin
                if (!prev_cyc) begin
                    att++;
                    c = 0;
                end
                if (adr_o !== v.adr || dat_o !== v.dat || sel_o !== v.sel ||
                    we_o !== v.we || stb_o !== 1'b1 || req_ready !== 1'b0)
                    stable_ok = 0;
                if (att <= 6 && c == int'(v.waits[att-1])) begin
                    {err_i, ack_i, rty_i} = v.term[att-1];
                    dat_i = v.rdata;
                end else begin
                    {err_i, ack_i, rty_i} = 3'b000;
                    dat_i = noisy ? $urandom : v.rdata;
                end
                cyc_cnt++;
                c++;
            end else begin
                {err_i, ack_i, rty_i} = noisy ? 3'($urandom_range(0, 7)) : 3'b000;
                dat_i = noisy ? $urandom : 32'h0;
            end
            prev_cyc = cyc_o;
            if (resp_valid) begin
                if (!got) begin
                    got = 1;
                    lat = tick - acc_tick;
                    r_dat = resp_dat;
                    r_code = resp_code;
                end else if (resp_dat !== r_dat || resp_code !== r_code) begin
                    hold_ok = 0;
                end
                if (req_ready !== 1'b0) hold_ok = 0;
                if (hold >= int'(v.rr_delay)) resp_ready = 1'b1;
                hold++;
            end
            @(negedge clk_bus);
            tick++;
            if (acc_tick >= 0 && tick == acc_tick) req_valid = 1'b0;
            if (resp_ready) begin
                done = 1;
                post_ok = (resp_valid === 1'b0) && (req_ready === 1'b1);
                resp_ready = 1'b0;
            end
        end
        req_valid = 1'b0;
        {err_i, ack_i, rty_i} = 3'b000;
        check({tag, ".done"},   32'(done), 32'd1);
        check({tag, ".code"},   32'(r_code), 32'(v.exp_code));
        check({tag, ".dat"},    r_dat, v.exp_dat);
        check({tag, ".cyc"},    32'(cyc_cnt), 32'(v.exp_cyc));
        check({tag, ".att"},    32'(att), 32'(v.exp_att));
        check({tag, ".lat"},    32'(lat), 32'(v.exp_lat));
        check({tag, ".stable"}, 32'(stable_ok), 32'd1);
        check({tag, ".hold"},   32'(hold_ok), 32'd1);
        check({tag, ".post"},   32'(post_ok), 32'd1);
        $display("txn %s: we=%0d adr=0x%08h code=%0d dat=0x%08h att=%0d cyc=%0d lat=%0d",
                 tag, v.we, v.adr, r_code, r_dat, att, cyc_cnt, lat);
    endtask

    function automatic logic [2:0] rand_term();
        int r;
        r = $urandom_range(0, 9);
        if (r < 5)  return T_RTY;
        if (r < 7)  return T_ACK;
        if (r == 7) return T_ERR;
        return 3'($urandom_range(1, 7));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t dv[10];
        vec_t v;
        int ndv;
        bit quiet_ok;

        // directed table: {request, slave script, hand-derived response}
        dv[0] = mk(1'b0, 32'h0000_1000, 32'h0, 4'hF, 32'hDEAD_BEEF, 0, 2'b00, 32'hDEAD_BEEF, 1, 1, 1);
        dv[1] = mk(1'b1, 32'h0000_0010, 32'h1234_5678, 4'b0011, 32'hCAFE_F00D, 0, 2'b00, 32'h0, 4, 1, 4);
        dv[1].waits[0] = 16'd3;
        dv[2] = mk(1'b0, 32'h0000_2000, 32'h0, 4'hF, 32'h1111_2222, 0, 2'b10, 32'h0, 4, 4, 7);
        for (int k = 0; k < 4; k++) dv[2].term[k] = T_RTY;
        dv[3] = mk(1'b0, 32'h0000_3004, 32'h0, 4'hF, 32'hA5A5_0001, 0, 2'b00, 32'hA5A5_0001, 3, 3, 5);
        dv[3].term[0] = T_RTY; dv[3].term[1] = T_RTY;
        dv[4] = mk(1'b0, 32'h0000_4000, 32'h0, 4'hF, 32'h0000_0055, 5, 2'b01, 32'h0, 1, 1, 1);
        dv[4].term[0] = T_ERR | T_ACK;
        dv[5] = mk(1'b1, 32'h0000_5008, 32'hFEED_0000, 4'b1000, 32'h9999_9999, 2, 2'b01, 32'h0, 5, 2, 6);
        dv[5].waits[0] = 16'd1; dv[5].term[0] = T_RTY;
        dv[5].waits[1] = 16'd2; dv[5].term[1] = T_ERR;
        dv[6] = mk(1'b0, 32'h0000_600C, 32'h0, 4'b0101, 32'h7654_3210, 1, 2'b00, 32'h7654_3210, 6, 4, 9);
        for (int k = 0; k < 3; k++) dv[6].term[k] = T_RTY;
        dv[6].waits[3] = 16'd2;
        dv[7] = mk(1'b0, 32'h0000_7000, 32'h0, 4'hF, 32'h0BAD_F00D, 0, 2'b00, 32'h0BAD_F00D, 1, 1, 1);
        dv[7].term[0] = T_ACK | T_RTY;
        ndv = 8;
`ifdef WB_MASTER_TIMEOUT_EN
        dv[8] = mk(1'b0, 32'h0000_8000, 32'h0, 4'hF, 32'h1234_0000, 0, 2'b11, 32'h0, TMO, 1, TMO);
        dv[8].waits[0] = 16'd1000;
        dv[9] = mk(1'b0, 32'h0000_9000, 32'h0, 4'hF, 32'h4321_0000, 0, 2'b00, 32'h4321_0000, TMO, 1, TMO);
        dv[9].waits[0] = 16'(TMO - 1);
        ndv = 10;
`endif

        // reset state: outputs are zero while reset is held
        #1;
        check("rst.req_ready", 32'(req_ready), 32'd0);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.cyc_stb", 32'({cyc_o, stb_o, we_o}), 32'd0);
        check("rst.adr_dat", adr_o | dat_o | 32'(sel_o) | resp_dat | 32'(resp_code), 32'd0);
        @(negedge clk_bus);
        rst_bus = 1'b0;
        @(negedge clk_bus);
        check("rst.ready_after", 32'(req_ready), 32'd1);

        for (int i = 0; i < ndv; i++) begin
            run_txn(dv[i], 1'b0, $sformatf("dir%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            v = '0;
            v.we = 1'($urandom_range(0, 1));
            v.adr = $urandom;
            v.dat = $urandom;
            v.sel = 4'($urandom_range(0, 15));
            v.rdata = $urandom;
            for (int k = 0; k < 6; k++) begin
                v.waits[k] = 16'($urandom_range(0, 3));
                v.term[k] = rand_term();
            end
            v.rr_delay = 8'($urandom_range(0, 3));
            v = model(v);
            run_txn(v, 1'b1, $sformatf("rnd%0d", i));
        end

        // reset in the middle of a bus cycle with a silent slave
        req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h0000_ABC0; req_sel = 4'hF;
        {err_i, ack_i, rty_i} = 3'b000;
        @(negedge clk_bus);
        req_valid = 1'b0;
        check("mid.cyc_up", 32'({cyc_o, stb_o}), 32'd3);
        @(negedge clk_bus);
        @(negedge clk_bus);
        #2 rst_bus = 1'b1;
        #1;
        check("mid.cyc_async", 32'({cyc_o, stb_o}), 32'd0);
        check("mid.ready_rst", 32'(req_ready), 32'd0);
        @(negedge clk_bus);
        rst_bus = 1'b0;
        @(negedge clk_bus);
        check("mid.ready_after", 32'(req_ready), 32'd1);
        quiet_ok = 1;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid !== 1'b0 || cyc_o !== 1'b0) quiet_ok = 0;
            @(negedge clk_bus);
        end
        check("mid.no_stale", 32'(quiet_ok), 32'd1);
        $display("txn midrst: reset during bus cycle");
        run_txn(dv[0], 1'b0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_master_port.md
# wb_master_port

Single-outstanding Wishbone bus initiator. It converts a valid/ready request from a processor-side client (fetch unit, LSU or DMA) into one classic Wishbone cycle toward the system bus, where the SRAM slave and the peripheral slaves sit. It terminates the cycle on ack, err or rty, retries a bounded number of times, and returns read data with a status code on a valid/ready response channel.

## Interface
Parameters:
- ADDR_WIDTH, 32, Wishbone address width
- DATA_WIDTH, 32, data width; must be a multiple of 8
- MAX_RETRY, 3, extra attempts allowed after rty_i (0–15)
- TIMEOUT_CYCLES, 255, cycles of cyc_o without termination before abort (1–65535; used only with the timeout macro)

Ports:
- clk_bus  in  1  bus clock; all logic on the rising edge
- rst_bus  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted on a cycle where req_valid && req_ready
- req_we  in  1  1 = write, 0 = read
- req_adr  in  ADDR_WIDTH  byte address
- req_dat  in  DATA_WIDTH  write data
- req_sel  in  DATA_WIDTH/8  byte lane enables
- resp_valid  out  1  response present
- resp_ready  in  1  client takes response
- resp_dat  out  DATA_WIDTH  read data; 0 for writes and for failed reads
- resp_code  out  2  00 ok, 01 bus error, 10 retries exhausted, 11 timeout
- cyc_o, stb_o, we_o  out  1  Wishbone cycle, strobe, write enable
- adr_o  out  ADDR_WIDTH, dat_o  out  DATA_WIDTH, sel_o  out  DATA_WIDTH/8  Wishbone address, write data, byte selects
- dat_i  in  DATA_WIDTH, ack_i/err_i/rty_i  in  1  slave read data and cycle terminations

## Operation
- All outputs are registered. Reset (asynchronous) drives the state to IDLE and every output to 0, including req_ready. Any in-flight cycle and pending response are dropped.
- IDLE: req_ready=1. On acceptance, latch we/adr/dat/sel into adr_o/dat_o/sel_o/we_o, clear retry_cnt, go to BUS. req_ready falls on the same edge.
- BUS: cyc_o=stb_o=1. Address, data, sel and we are stable for the whole state. Terminations are sampled each edge, with priority err_i > ack_i > rty_i:
  - err_i: resp_code=01, go to RESP.
  - ack_i: resp_dat=dat_i if read, else 0; resp_code=00; go to RESP.
  - rty_i with retry_cnt<MAX_RETRY: retry_cnt++, go to BACKOFF.
  - rty_i with retry_cnt==MAX_RETRY: resp_code=10, go to RESP.
- BACKOFF: cyc_o=stb_o=0 for exactly one cycle, then return to BUS with the same latched request.
- RESP: cyc_o=stb_o=0 and resp_valid=1. resp_dat and resp_code are held until resp_ready. On the handshake edge, go to IDLE and set req_ready=1.
- ack_i, err_i and rty_i are ignored outside BUS.

## Timing
- Zero-wait slave: request accepted at edge E0. cyc_o is high in cycle E0..E1 and ack is sampled at E1. resp_valid is high from E1.
- With resp_ready tied high, IDLE returns at E2 and the next acceptance is at E3, giving 3 cycles per transfer.
- Each retry adds 2 cycles: one BACKOFF cycle plus a fresh BUS cycle. The maximum number of BUS attempts is MAX_RETRY+1.
- req_ready is never high while resp_valid is high, so there is at most one outstanding transaction.

## Configuration
- WB_MASTER_TIMEOUT_EN defined:
  - A 16-bit wait counter is cleared on every entry to BUS and increments each BUS cycle with no termination.
  - If a cycle would be the TIMEOUT_CYCLES-th without termination, the master drops cyc_o, sets resp_code=11 and goes to RESP.
  - A termination arriving on that same edge takes priority over the timeout.
- WB_MASTER_TIMEOUT_EN undefined: the counter is not built, BUS waits indefinitely, and code 11 is never produced.

## Test plan
- Read at adr 0x0000_1000, slave acks in the first cycle with dat_i=0xDEADBEEF: resp_valid is high 1 cycle after acceptance, resp_dat=0xDEADBEEF, code 00, and cyc_o is high for exactly 1 cycle.
- Write adr 0x10, dat 0x12345678, sel 0b0011, ack after 3 wait states: adr_o/dat_o/sel_o/we_o are stable for all 4 cyc_o cycles; resp_dat=0, code 00.
- Slave asserts rty_i on every attempt, MAX_RETRY=3: 4 BUS attempts separated by 1-cycle cyc_o gaps, then code 10. With rty on 2 attempts followed by ack: code 00.
- err_i and ack_i asserted together: code 01, resp_dat=0. Hold resp_ready low for 5 cycles: resp_valid, resp_dat and resp_code are stable and req_ready stays 0.
- Macro defined, TIMEOUT_CYCLES=8, slave silent: cyc_o is high exactly 8 cycles, then code 11. A second run with ack on the 8th cycle gives code 00.
- Assert rst_bus mid-BUS: cyc_o/stb_o fall without waiting for a clock edge. After release, req_ready=1 from the first edge and no stale response is emitted.
